// File: rtl/side_road_sensor_pkg.sv
// Purpose : shared types and default constants for the side-road sensor conditioning stage.
// Latency : n/a (package only).
// Backpressure: n/a; the sensor path has no flow control.
// Contents: debounce state enum, default parameter values, counter width helper.
// Option  : SENSOR_ACTIVE_LOW_EN (used in sensor_debounce) selects an active-low raw sensor.
package side_sensor_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } db_state_t;

    localparam int DEF_DB_CYCLES = 500000;      // 10 ms at 50 MHz
    localparam int DEF_DRAIN_CYC = 100000000;   // 2 s per departing vehicle
    localparam int DEF_STUCK_CYC = 1500000000;  // 30 s continuous high
    localparam int DEF_CNT_W     = 4;
    localparam int DEF_CNT_MAX   = 15;
    localparam int STUCK_MIN_W   = 31;          // stuck timer never narrower than this

    // Width of a counter that must hold values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/side_road_sensor_if.sv
// Purpose : groups the sensor input and the conditioned request outputs into one bundle.
// Latency : n/a (wiring only).
// Backpressure: none; all signals are level/pulse with no handshake.
// Ports   : SENS_RAW, SIDE_GREEN (environment -> sensor), S, QCOUNT, ARRIVE_P, FAULT (sensor -> controller).
// Modports: master = environment/controller side, slave = side_road_sensor.
interface side_road_sensor_if
    import side_sensor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             SENS_RAW;
    logic             SIDE_GREEN;
    logic             S;
    logic [CNT_W-1:0] QCOUNT;
    logic             ARRIVE_P;
    logic             FAULT;

    modport master (
        output SENS_RAW, SIDE_GREEN,
        input  S, QCOUNT, ARRIVE_P, FAULT
    );

    modport slave (
        input  SENS_RAW, SIDE_GREEN,
        output S, QCOUNT, ARRIVE_P, FAULT
    );
endinterface

// File: rtl/side_road_sensor_debounce.sv
// Purpose : 2-flop synchroniser plus debounce FSM; emits one arrival pulse per accepted rising edge.
// Latency : arrive_p high DB_CYCLES+2 edges after the first edge that samples the raw input high.
// Backpressure: none; arrivals are pulses that the consumer must take in the cycle they appear.
// Ports   : CLK, RST (async active-low), sens_raw in; arrive_p, deb_high (HIGH/FALL_CHK), deb_low (LOW) out.
// Option  : SENSOR_ACTIVE_LOW_EN inverts the raw sensor (active-low loop detectors).
module sensor_debounce
    import side_sensor_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic sens_raw,
    output logic arrive_p,
    output logic deb_high,
    output logic deb_low
);
    localparam int              DB_W    = cnt_width(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic sync_q1;
    logic sync_q2;
    logic sens_s;

    // The flops carry the raw pin level so their reset value equals the idle pin
    // level; the polarity fix is applied after them, so no edge is seen on release.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
`ifdef SENSOR_ACTIVE_LOW_EN
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
`else
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
`endif
        end else begin
            sync_q1 <= sens_raw;
            sync_q2 <= sync_q1;
        end
    end

`ifdef SENSOR_ACTIVE_LOW_EN
    assign sens_s = ~sync_q2;
`else
    assign sens_s = sync_q2;
`endif

    db_state_t       state;
    db_state_t       state_next;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_next;
    logic            arrive_set;

    // State register; the arrival pulse is registered so it lines up with the HIGH state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= LOW;
            db_cnt   <= '0;
            arrive_p <= 1'b0;
        end else begin
            state    <= state_next;
            db_cnt   <= db_cnt_next;
            arrive_p <= arrive_set;
        end
    end

    // Next state: each check state needs DB_CYCLES further agreeing samples after entry.
    always_comb begin
        state_next  = state;
        db_cnt_next = db_cnt;
        unique case (state)
            LOW: begin
                if (sens_s) begin
                    state_next  = RISE_CHK;
                    db_cnt_next = '0;
                end
            end
            RISE_CHK: begin
                if (!sens_s) begin
                    state_next = LOW;
                end else if (db_cnt == DB_LAST) begin
                    state_next  = HIGH;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + DB_W'(1);
                end
            end
            HIGH: begin
                if (!sens_s) begin
                    state_next  = FALL_CHK;
                    db_cnt_next = '0;
                end
            end
            FALL_CHK: begin
                if (sens_s) begin
                    state_next = HIGH;
                end else if (db_cnt == DB_LAST) begin
                    state_next  = LOW;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + DB_W'(1);
                end
            end
            default: state_next = LOW;
        endcase
    end

    // Outputs.
    always_comb begin
        arrive_set = (state == RISE_CHK) && (state_next == HIGH);
        deb_high   = (state == HIGH) || (state == FALL_CHK);
        deb_low    = (state == LOW);
    end

endmodule

// File: rtl/side_road_sensor.sv
// Purpose : side-road request conditioning: debounced arrivals, queue count, drain while green, stuck-sensor fault.
// Latency : QCOUNT/S update one edge after ARRIVE_P or on the depart edge; S = (QCOUNT != 0) | FAULT.
// Backpressure: none; QCOUNT saturates at CNT_MAX (must be <= 2^CNT_W-1) and floors at 0.
// Ports   : CLK, RST (async active-low), bus (side_road_sensor_if.slave: SENS_RAW, SIDE_GREEN, S, QCOUNT, ARRIVE_P, FAULT).
// Option  : SENSOR_ACTIVE_LOW_EN (see sensor_debounce) for active-low loop detectors.
module side_road_sensor
    import side_sensor_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC,
    parameter int STUCK_CYC = DEF_STUCK_CYC,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int CNT_MAX   = DEF_CNT_MAX
) (
    input  logic             CLK,
    input  logic             RST,
    side_road_sensor_if.slave bus
);
    localparam int DRAIN_W = cnt_width(DRAIN_CYC);
    localparam int STUCK_W = (cnt_width(STUCK_CYC) > STUCK_MIN_W) ? cnt_width(STUCK_CYC) : STUCK_MIN_W;

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYC - 1);
    localparam logic [CNT_W-1:0]   Q_MAX      = CNT_W'(CNT_MAX);

    logic               arrive;
    logic               deb_high;
    logic               deb_low;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               depart_tick;
    logic [STUCK_W-1:0] stuck_cnt;
    logic [CNT_W-1:0]   qcount;
    logic [CNT_W-1:0]   q_next;
    logic               fault;
    logic               fault_next;
    logic               s_q;

    sensor_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .CLK      (CLK),
        .RST      (RST),
        .sens_raw (bus.SENS_RAW),
        .arrive_p (arrive),
        .deb_high (deb_high),
        .deb_low  (deb_low)
    );

    // Drain timer: only advances during side green and restarts whenever green drops.
    assign depart_tick = bus.SIDE_GREEN && (drain_cnt == DRAIN_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            drain_cnt <= '0;
        end else if (!bus.SIDE_GREEN || depart_tick) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
    end

    // Stuck timer holds at its terminal value so a very long stuck period cannot wrap.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stuck_cnt <= '0;
        end else if (!deb_high) begin
            stuck_cnt <= '0;
        end else if (stuck_cnt != STUCK_LAST) begin
            stuck_cnt <= stuck_cnt + STUCK_W'(1);
        end
    end

    // An arrival and a departure in the same cycle cancel out.
    always_comb begin
        q_next = qcount;
        if (arrive && !depart_tick) begin
            if (qcount != Q_MAX) q_next = qcount + CNT_W'(1);
        end else if (depart_tick && !arrive) begin
            if (qcount != '0) q_next = qcount - CNT_W'(1);
        end
    end

    // Fault is sticky until the debouncer is back in LOW.
    always_comb begin
        fault_next = fault;
        if (deb_low) begin
            fault_next = 1'b0;
        end else if (deb_high && (stuck_cnt == STUCK_LAST)) begin
            fault_next = 1'b1;
        end
    end

    // S is built from next-state values so it moves in the same cycle as QCOUNT/FAULT.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            qcount <= '0;
            fault  <= 1'b0;
            s_q    <= 1'b0;
        end else begin
            qcount <= q_next;
            fault  <= fault_next;
            s_q    <= (q_next != '0) || fault_next;
        end
    end

    assign bus.S        = s_q;
    assign bus.QCOUNT   = qcount;
    assign bus.ARRIVE_P = arrive;
    assign bus.FAULT    = fault;

endmodule
